prf_scoreboard_bank: RTL and testbench

//  Parametrised physical register file with integrated ready scoreboard, same-cycle write->read bypass,

---
 rtl/prf_scoreboard_bank.sv | 210 +++++++++++++++++++++
 tb/tb_prf_scoreboard_bank.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_scoreboard_bank.sv
`default_nettype none
// ============================================================================
//  Module   : prf_scoreboard_bank
//  Purpose  : Physical register file with an integrated ready scoreboard,
//             same-cycle write->read bypass, registered wakeup broadcast and
//             multi-slot branch checkpoints that restore ready bits on a
//             mispredict recovery.
//  Ports    : clk, reset (async, active-low)
//             rd_addr/rd_data/rd_rdy        - combinational read ports
//             wr_en/wr_addr/wr_data         - FU writeback ports
//             wake_valid/wake_tag           - registered tag wakeup bus
//             alloc_en/alloc_addr           - rename allocations (clear ready)
//             ckpt_save/ckpt_save_id        - checkpoint snapshot request
//             ckpt_free                     - per-slot checkpoint release
//             recover/recover_id            - mispredict recovery request
//             ckpt_valid                    - registered slot-valid flags
//             recover_err                   - pulse: recover to invalid slot
//  Revision : 1.0 - initial release
// ============================================================================
module prf_scoreboard_bank #(
    parameter int NUM_PREGS   = 128,
    parameter int DATA_W      = 32,
    parameter int NUM_RD      = 6,
    parameter int NUM_WR      = 3,
    parameter int NUM_ALLOC   = 1,
    parameter int NUM_CKPT    = 4,
    localparam int CKPT_W     = $clog2(NUM_CKPT),
    localparam int PREG_W     = $clog2(NUM_PREGS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_RD*PREG_W-1:0]      rd_addr,
    output logic [NUM_RD*DATA_W-1:0]      rd_data,
    output logic [NUM_RD-1:0]             rd_rdy,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*PREG_W-1:0]      wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]      wr_data,
    output logic [NUM_WR-1:0]             wake_valid,
    output logic [NUM_WR*PREG_W-1:0]      wake_tag,
    input  logic [NUM_ALLOC-1:0]          alloc_en,
    input  logic [NUM_ALLOC*PREG_W-1:0]   alloc_addr,
    input  logic                          ckpt_save,
    input  logic [CKPT_W-1:0]             ckpt_save_id,
    input  logic [NUM_CKPT-1:0]           ckpt_free,
    input  logic                          recover,
    input  logic [CKPT_W-1:0]             recover_id,
    output logic [NUM_CKPT-1:0]           ckpt_valid,
    output logic                          recover_err
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]    r_data       [NUM_PREGS];
    logic [NUM_PREGS-1:0] r_ready;
    logic [NUM_PREGS-1:0] r_alloc_mask [NUM_CKPT];
    logic [NUM_CKPT-1:0]  r_ckpt_valid;
    logic [NUM_WR-1:0]    r_wake_valid;
    logic [NUM_WR*PREG_W-1:0] r_wake_tag;
    logic                 r_recover_err;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic                 w_rec_ok;
    logic                 w_rec_bad;
    logic                 w_save_ok;
    logic [NUM_PREGS-1:0] w_alloc_vec;
    logic [NUM_PREGS-1:0] w_ready_nxt;
    logic [NUM_PREGS-1:0] w_mask_nxt   [NUM_CKPT];
    logic [NUM_CKPT-1:0]  w_ckpt_valid_nxt;

    // A recovery only takes effect against a live checkpoint; it then
    // pre-empts any same-cycle save and squashes the same-cycle allocs.
    always_comb begin
        w_rec_ok  = recover &  r_ckpt_valid[recover_id];
        w_rec_bad = recover & ~r_ckpt_valid[recover_id];
        w_save_ok = ckpt_save & ~w_rec_ok;
    end

    // One-hot set of pregs allocated this cycle (preg 0 never tracked).
    always_comb begin
        w_alloc_vec = '0;
        if (!w_rec_ok) begin
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (alloc_en[a] && (alloc_addr[a*PREG_W +: PREG_W] != '0)) begin
                    w_alloc_vec[alloc_addr[a*PREG_W +: PREG_W]] = 1'b1;
                end
            end
        end
    end

    // Ready table: recovery releases squashed producers, writebacks set,
    // allocations clear last so an alloc beats a same-cycle write.
    always_comb begin
        w_ready_nxt = r_ready;
        if (w_rec_ok) begin
            w_ready_nxt = w_ready_nxt | r_alloc_mask[recover_id];
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_addr[k*PREG_W +: PREG_W] != '0)) begin
                w_ready_nxt[wr_addr[k*PREG_W +: PREG_W]] = 1'b1;
            end
        end
        w_ready_nxt    = w_ready_nxt & ~w_alloc_vec;
        w_ready_nxt[0] = 1'b1;
    end

    // Checkpoint slots: live slots accumulate allocs; a save restarts the
    // mask with only this cycle's allocs.
    always_comb begin
        w_ckpt_valid_nxt = r_ckpt_valid & ~ckpt_free;
        if (w_rec_ok) begin
            w_ckpt_valid_nxt[recover_id] = 1'b0;
        end
        if (w_save_ok) begin
            w_ckpt_valid_nxt[ckpt_save_id] = 1'b1;
        end
        for (int i = 0; i < NUM_CKPT; i++) begin
            w_mask_nxt[i] = r_alloc_mask[i];
            if (w_save_ok && (ckpt_save_id == CKPT_W'(i))) begin
                w_mask_nxt[i] = w_alloc_vec;
            end else if (r_ckpt_valid[i]) begin
                w_mask_nxt[i] = r_alloc_mask[i] | w_alloc_vec;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports with write bypass (highest-index matching writer wins)
    // ------------------------------------------------------------------
    generate
        for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
            logic [PREG_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rdata;
            logic              w_rrdy;

            assign w_ra = rd_addr[r*PREG_W +: PREG_W];

            always_comb begin
                w_rdata = r_data[w_ra];
                w_rrdy  = r_ready[w_ra];
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] && (wr_addr[k*PREG_W +: PREG_W] == w_ra)) begin
                        w_rdata = wr_data[k*DATA_W +: DATA_W];
                        w_rrdy  = 1'b1;
                    end
                end
                if (w_ra == '0) begin
                    w_rdata = '0;
                    w_rrdy  = 1'b1;
                end
            end

            assign rd_data[r*DATA_W +: DATA_W] = w_rdata;
            assign rd_rdy[r]                   = w_rrdy;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Data array; later ports overwrite earlier ones on equal addresses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PREGS; p++) begin
                r_data[p] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_addr[k*PREG_W +: PREG_W] != '0)) begin
                    r_data[wr_addr[k*PREG_W +: PREG_W]] <= wr_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard, checkpoints, wakeup and error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready       <= '1;
            r_ckpt_valid  <= '0;
            r_wake_valid  <= '0;
            r_wake_tag    <= '0;
            r_recover_err <= 1'b0;
            for (int i = 0; i < NUM_CKPT; i++) begin
                r_alloc_mask[i] <= '0;
            end
        end else begin
            r_ready       <= w_ready_nxt;
            r_ckpt_valid  <= w_ckpt_valid_nxt;
            r_wake_tag    <= wr_addr;
            r_recover_err <= w_rec_bad;
            for (int k = 0; k < NUM_WR; k++) begin
                r_wake_valid[k] <= wr_en[k] && (wr_addr[k*PREG_W +: PREG_W] != '0);
            end
            for (int i = 0; i < NUM_CKPT; i++) begin
                r_alloc_mask[i] <= w_mask_nxt[i];
            end
        end
    end

    assign wake_valid  = r_wake_valid;
    assign wake_tag    = r_wake_tag;
    assign ckpt_valid  = r_ckpt_valid;
    assign recover_err = r_recover_err;

endmodule
`default_nettype wire

// File: tb/tb_prf_scoreboard_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prf_scoreboard_bank
//  Purpose  : Directed self-checking bench for prf_scoreboard_bank: reset,
//             bypass/wakeup, port conflicts, alloc vs write, checkpoint
//             save/free/recover, invalid recovery and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prf_scoreboard_bank;

    localparam int c_NUM_PREGS = 128;
    localparam int c_DATA_W    = 32;
    localparam int c_NUM_RD    = 6;
    localparam int c_NUM_WR    = 3;
    localparam int c_NUM_ALLOC = 1;
    localparam int c_NUM_CKPT  = 4;
    localparam int c_CKPT_W    = 2;
    localparam int c_PREG_W    = 7;

    logic                                clk;
    logic                                reset;
    logic [c_NUM_RD*c_PREG_W-1:0]        rd_addr;
    logic [c_NUM_RD*c_DATA_W-1:0]        rd_data;
    logic [c_NUM_RD-1:0]                 rd_rdy;
    logic [c_NUM_WR-1:0]                 wr_en;
    logic [c_NUM_WR*c_PREG_W-1:0]        wr_addr;
    logic [c_NUM_WR*c_DATA_W-1:0]        wr_data;
    logic [c_NUM_WR-1:0]                 wake_valid;
    logic [c_NUM_WR*c_PREG_W-1:0]        wake_tag;
    logic [c_NUM_ALLOC-1:0]              alloc_en;
    logic [c_NUM_ALLOC*c_PREG_W-1:0]     alloc_addr;
    logic                                ckpt_save;
    logic [c_CKPT_W-1:0]                 ckpt_save_id;
    logic [c_NUM_CKPT-1:0]               ckpt_free;
    logic                                recover;
    logic [c_CKPT_W-1:0]                 recover_id;
    logic [c_NUM_CKPT-1:0]               ckpt_valid;
    logic                                recover_err;

    int errors = 0;
    int checks = 0;

    prf_scoreboard_bank #(
        .NUM_PREGS (c_NUM_PREGS),
        .DATA_W    (c_DATA_W),
        .NUM_RD    (c_NUM_RD),
        .NUM_WR    (c_NUM_WR),
        .NUM_ALLOC (c_NUM_ALLOC),
        .NUM_CKPT  (c_NUM_CKPT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_rdy       (rd_rdy),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wake_valid   (wake_valid),
        .wake_tag     (wake_tag),
        .alloc_en     (alloc_en),
        .alloc_addr   (alloc_addr),
        .ckpt_save    (ckpt_save),
        .ckpt_save_id (ckpt_save_id),
        .ckpt_free    (ckpt_free),
        .recover      (recover),
        .recover_id   (recover_id),
        .ckpt_valid   (ckpt_valid),
        .recover_err  (recover_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rd_addr      = '0;
        wr_en        = '0;
        wr_addr      = '0;
        wr_data      = '0;
        alloc_en     = '0;
        alloc_addr   = '0;
        ckpt_save    = 1'b0;
        ckpt_save_id = '0;
        ckpt_free    = '0;
        recover      = 1'b0;
        recover_id   = '0;
    endtask

    task automatic set_rd(input int port, input int addr);
        rd_addr[port*c_PREG_W +: c_PREG_W] = addr[c_PREG_W-1:0];
    endtask

    task automatic set_wr(input int port, input int addr, input logic [31:0] data);
        wr_en[port]                        = 1'b1;
        wr_addr[port*c_PREG_W +: c_PREG_W] = addr[c_PREG_W-1:0];
        wr_data[port*c_DATA_W +: c_DATA_W] = data;
    endtask

    task automatic set_alloc(input int addr);
        alloc_en   = 1'b1;
        alloc_addr = addr[c_PREG_W-1:0];
    endtask

    // Wait for the next edge and land just after it with idle inputs.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < c_NUM_RD; p++) set_rd(p, p);
        #1;
        for (int p = 0; p < c_NUM_RD; p++) begin
            checks++;
            if (rd_data[p*c_DATA_W +: c_DATA_W] !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd_data[%0d]: got %h expected 00000000", p, rd_data[p*c_DATA_W +: c_DATA_W]);
            end
        end
        checks++;
        if (rd_rdy !== 6'b111111) begin
            errors++;
            $display("FAIL reset_rd_rdy: got %b expected 111111", rd_rdy);
        end
        checks++;
        if (wake_valid !== 3'b000) begin
            errors++;
            $display("FAIL reset_wake_valid: got %b expected 000", wake_valid);
        end
        checks++;
        if (ckpt_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ckpt_valid: got %b expected 0000", ckpt_valid);
        end
        checks++;
        if (recover_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover_err: got %b expected 0", recover_err);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        set_wr(1, 7, 32'hDEADBEEF);
        set_rd(0, 7);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL bypass_read: got data=%h rdy=%b expected DEADBEEF/1", rd_data[31:0], rd_rdy[0]);
        end
        step();
        set_rd(0, 7);
        #1;
        checks++;
        if (wake_valid !== 3'b010 || wake_tag[c_PREG_W +: c_PREG_W] !== 7'd7) begin
            errors++;
            $display("FAIL bypass_wake: got valid=%b tag1=%0d expected 010/7", wake_valid, wake_tag[c_PREG_W +: c_PREG_W]);
        end
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL bypass_stored: got data=%h rdy=%b expected DEADBEEF/1", rd_data[31:0], rd_rdy[0]);
        end
        step();
        checks++;
        if (wake_valid !== 3'b000) begin
            errors++;
            $display("FAIL wake_drop: got %b expected 000", wake_valid);
        end
    endtask

    task automatic test_port_conflict();
        @(negedge clk);
        idle();
        set_wr(0, 9, 32'h11);
        set_wr(2, 9, 32'h22);
        set_rd(3, 9);
        #1;
        checks++;
        if (rd_data[3*c_DATA_W +: c_DATA_W] !== 32'h22) begin
            errors++;
            $display("FAIL conflict_bypass: got %h expected 00000022", rd_data[3*c_DATA_W +: c_DATA_W]);
        end
        step();
        set_rd(3, 9);
        #1;
        checks++;
        if (rd_data[3*c_DATA_W +: c_DATA_W] !== 32'h22) begin
            errors++;
            $display("FAIL conflict_stored: got %h expected 00000022", rd_data[3*c_DATA_W +: c_DATA_W]);
        end
        checks++;
        if (wake_valid !== 3'b101) begin
            errors++;
            $display("FAIL conflict_wake: got %b expected 101", wake_valid);
        end
        // write to preg 0 is dropped: reads 0, no wakeup
        @(negedge clk);
        idle();
        set_wr(0, 0, 32'h55);
        set_rd(2, 0);
        #1;
        checks++;
        if (rd_data[2*c_DATA_W +: c_DATA_W] !== 32'h0 || rd_rdy[2] !== 1'b1) begin
            errors++;
            $display("FAIL zero_bypass: got data=%h rdy=%b expected 00000000/1", rd_data[2*c_DATA_W +: c_DATA_W], rd_rdy[2]);
        end
        step();
        set_rd(2, 0);
        #1;
        checks++;
        if (wake_valid !== 3'b000 || rd_data[2*c_DATA_W +: c_DATA_W] !== 32'h0) begin
            errors++;
            $display("FAIL zero_write: got wake=%b data=%h expected 000/00000000", wake_valid, rd_data[2*c_DATA_W +: c_DATA_W]);
        end
    endtask

    task automatic test_alloc_vs_write();
        @(negedge clk);
        idle();
        set_alloc(12);
        set_wr(0, 12, 32'hCAFE0012);
        step();
        set_rd(1, 12);
        #1;
        checks++;
        if (rd_rdy[1] !== 1'b0) begin
            errors++;
            $display("FAIL alloc_wins_rdy: got %b expected 0", rd_rdy[1]);
        end
        checks++;
        if (rd_data[c_DATA_W +: c_DATA_W] !== 32'hCAFE0012) begin
            errors++;
            $display("FAIL alloc_write_data: got %h expected CAFE0012", rd_data[c_DATA_W +: c_DATA_W]);
        end
    endtask

    task automatic test_recover();
        @(negedge clk);
        idle();
        ckpt_save    = 1'b1;
        ckpt_save_id = 2'd2;
        step();
        checks++;
        if (ckpt_valid !== 4'b0100) begin
            errors++;
            $display("FAIL save_valid: got %b expected 0100", ckpt_valid);
        end
        @(negedge clk);
        set_alloc(20);
        step();
        @(negedge clk);
        set_alloc(21);
        step();
        set_rd(0, 20);
        set_rd(1, 21);
        set_rd(2, 22);
        #1;
        checks++;
        if (rd_rdy[2:0] !== 3'b100) begin
            errors++;
            $display("FAIL pre_recover_rdy: got %b expected 100 (22,21,20)", rd_rdy[2:0]);
        end
        @(negedge clk);
        recover    = 1'b1;
        recover_id = 2'd2;
        set_alloc(22);
        step();
        set_rd(0, 20);
        set_rd(1, 21);
        set_rd(2, 22);
        set_rd(3, 12);
        #1;
        checks++;
        if (rd_rdy[3:0] !== 4'b0111) begin
            errors++;
            $display("FAIL recover_rdy: got %b expected 0111 (12,22,21,20)", rd_rdy[3:0]);
        end
        checks++;
        if (ckpt_valid !== 4'b0000 || recover_err !== 1'b0) begin
            errors++;
            $display("FAIL recover_ckpt: got valid=%b err=%b expected 0000/0", ckpt_valid, recover_err);
        end
    endtask

    task automatic test_save_free();
        @(negedge clk);
        idle();
        ckpt_save    = 1'b1;
        ckpt_save_id = 2'd1;
        step();
        @(negedge clk);
        ckpt_free = 4'b0010;
        step();
        checks++;
        if (ckpt_valid !== 4'b0000) begin
            errors++;
            $display("FAIL free_slot: got %b expected 0000", ckpt_valid);
        end
        @(negedge clk);
        ckpt_save    = 1'b1;
        ckpt_save_id = 2'd0;
        ckpt_free    = 4'b0001;
        step();
        checks++;
        if (ckpt_valid !== 4'b0001) begin
            errors++;
            $display("FAIL save_beats_free: got %b expected 0001", ckpt_valid);
        end
    endtask

    task automatic test_invalid_recover();
        @(negedge clk);
        idle();
        set_alloc(30);
        step();
        @(negedge clk);
        recover    = 1'b1;
        recover_id = 2'd3;
        step();
        set_rd(0, 30);
        set_rd(1, 12);
        #1;
        checks++;
        if (recover_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_recover_err: got %b expected 1", recover_err);
        end
        checks++;
        if (rd_rdy[1:0] !== 2'b00 || ckpt_valid !== 4'b0001) begin
            errors++;
            $display("FAIL bad_recover_state: got rdy=%b valid=%b expected 00/0001", rd_rdy[1:0], ckpt_valid);
        end
        step();
        checks++;
        if (recover_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_recover_pulse: got %b expected 0", recover_err);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle();
        set_wr(0, 40, 32'hA0);
        step();
        set_wr(2, 41, 32'hA1);
        set_rd(0, 40);
        set_rd(1, 41);
        #1;
        checks++;
        if (wake_valid !== 3'b001 || wake_tag[6:0] !== 7'd40) begin
            errors++;
            $display("FAIL b2b_wake0: got valid=%b tag0=%0d expected 001/40", wake_valid, wake_tag[6:0]);
        end
        checks++;
        if (rd_data[31:0] !== 32'hA0 || rd_data[63:32] !== 32'hA1 || rd_rdy[1:0] !== 2'b11) begin
            errors++;
            $display("FAIL b2b_read: got %h %h rdy=%b expected 000000A0 000000A1 11", rd_data[31:0], rd_data[63:32], rd_rdy[1:0]);
        end
        step();
        checks++;
        if (wake_valid !== 3'b100 || wake_tag[20:14] !== 7'd41) begin
            errors++;
            $display("FAIL b2b_wake2: got valid=%b tag2=%0d expected 100/41", wake_valid, wake_tag[20:14]);
        end
    endtask

    task automatic test_async_reset();
        // slot 0 is still valid and preg 12 not ready at this point
        @(negedge clk);
        idle();
        #2;
        reset = 1'b0;
        set_rd(0, 12);
        set_rd(1, 40);
        #1;
        checks++;
        if (ckpt_valid !== 4'b0000 || rd_rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_state: got valid=%b rdy12=%b expected 0000/1", ckpt_valid, rd_rdy[0]);
        end
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_data[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_data: got %h %h expected 0", rd_data[31:0], rd_data[63:32]);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_port_conflict();
        test_alloc_vs_write();
        test_recover();
        test_save_free();
        test_invalid_recover();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
